// File: rtl/payload_bus_scheduler.sv
// payload_bus_scheduler: round-robin owner of the shared payload bus.
// Grants one PE per burst, counts beats, flags the last one, releases.
// Ports: clk, rst_n (sync, active-low); req/req_len per-PE requests
// (len = beats-1); beat_valid from datapath; grant/grant_id registered
// owner; busy (XFER|RELEASE); beat_cnt; last_beat; done (RELEASE pulse);
// timeout (stall abort pulse, only with PAYLOAD_TIMEOUT_EN, else 0).
// Optional macro: PAYLOAD_TIMEOUT_EN enables the stall watchdog.
module payload_bus_scheduler #(
    parameter int NUM_PE      = 10,
    parameter int ID_W        = 4,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PE-1:0]       req,
    input  logic [NUM_PE*LEN_W-1:0] req_len,
    input  logic                    beat_valid,
    output logic [NUM_PE-1:0]       grant,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic [LEN_W-1:0]        beat_cnt,
    output logic                    last_beat,
    output logic                    done,
    output logic                    timeout
);

    if ((1 << ID_W) < NUM_PE || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("payload_bus_scheduler: bad parameters");
    end

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

    localparam int PW = ID_W + 2;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [LEN_W-1:0]  len_q;
    logic              abort;

    logic [PW-1:0]     sh;
    logic [PW-1:0]     sum;
    logic [NUM_PE-1:0] rot;
    logic [ID_W-1:0]   win_id;
    logic [NUM_PE-1:0] win_oh;
    logic [LEN_W-1:0]  win_len;

    // rot[j] is the request of PE (rr_ptr+1+j) mod NUM_PE; the lowest
    // set j is the winner, so the last owner is searched last.
    always_comb begin
        sh     = PW'(rr_ptr) + PW'(1);
        rot    = NUM_PE'({req, req} >> sh);
        sum    = '0;
        win_id = '0;
        for (int j = NUM_PE - 1; j >= 0; j--) begin
            sum = PW'(rr_ptr) + PW'(j + 1);
            if (sum >= PW'(NUM_PE)) sum = sum - PW'(NUM_PE);
            if (rot[j]) win_id = sum[ID_W-1:0];
        end
        win_oh  = '0;
        win_len = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            if (win_id == ID_W'(p)) begin
                win_oh[p] = 1'b1;
                win_len   = req_len[p*LEN_W +: LEN_W];
            end
        end
    end

    assign last_beat = (state == XFER) && (beat_cnt == len_q);
    assign busy      = (state != IDLE);
    assign done      = (state == RELEASE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            rr_ptr   <= ID_W'(NUM_PE - 1);
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= win_oh;
                        grant_id <= win_id;
                        rr_ptr   <= win_id;
                        len_q    <= win_len;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (beat_valid && !last_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end else if (beat_valid || abort) begin
                        grant    <= '0;
                        grant_id <= '0;
                        beat_cnt <= '0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PAYLOAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] stall;

    assign abort = (state == XFER) && !beat_valid
                && (stall == TW'(TIMEOUT_CYC - 1));

    // stall is zero in IDLE, so it starts cleared on XFER entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= abort;
            if (state != XFER || beat_valid || abort) stall <= '0;
            else stall <= stall + 1'b1;
        end
    end
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule
